// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative RISC-V M-extension multiply/divide sequencer.
// One bit per cycle: shift-add multiply or restoring divide on a shared
// XLEN+1-bit add/subtract datapath, with sign and special-case fixup on exit.
// Optional macro MULDIV_FAST_ZERO_EN: ops with a zero operand skip CALC and
// deliver their result one cycle after accept.
module muldiv_seq_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control state (reset)
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operation context and datapath (no reset needed)
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_raw_q, a_raw_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_mag_q, b_mag_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    // Shared adder and per-iteration step values
    logic            is_div;
    logic [XLEN:0]   add_a, add_b, sum;
    logic [XLEN-1:0] hi_step, lo_step;

    // Incoming-operand decode
    logic            in_a_signed, in_b_signed, in_a_neg, in_b_neg, in_div;
    logic [XLEN-1:0] in_a_mag, in_b_mag;

    // Two's-complement magnitude of a value when it is a negative signed operand
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Sign correction, special-case forcing and result selection
    function automatic logic [XLEN-1:0] fixup(
        input logic [2:0]      op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            an,
        input logic            bn,
        input logic            dz,
        input logic            ovf,
        input logic [XLEN-1:0] araw
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = {hi, lo};
        if (an ^ bn) prod = ~prod + 1'b1;
        quo = (an ^ bn) ? (~lo + 1'b1) : lo;
        rem = an ? (~hi + 1'b1) : hi;
        if (dz) begin
            quo = '1;
            rem = araw;
        end else if (ovf) begin
            quo = araw;
            rem = '0;
        end
        case (op)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quo;
            default:                return rem;
        endcase
    endfunction

    assign in_a_signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    assign in_b_signed = (funct3 == 3'b000 || funct3 == 3'b001 ||
                          funct3 == 3'b100 || funct3 == 3'b110);
    assign in_a_neg    = in_a_signed & a[XLEN-1];
    assign in_b_neg    = in_b_signed & b[XLEN-1];
    assign in_a_mag    = magnitude(a, in_a_neg);
    assign in_b_mag    = magnitude(b, in_b_neg);
    assign in_div      = funct3[2];

    // One iteration: multiply adds |a| when the multiplier LSB is set and shifts
    // right; divide shifts left and trial-subtracts |b|, restoring on borrow.
    always_comb begin
        is_div = op_q[2];
        if (is_div) begin
            add_a = {hi_q, lo_q[XLEN-1]};
            add_b = ~{1'b0, b_mag_q};
        end else begin
            add_a = {1'b0, hi_q};
            add_b = lo_q[0] ? {1'b0, a_mag_q} : '0;
        end
        sum = add_a + add_b + {{XLEN{1'b0}}, is_div};
        if (is_div) begin
            hi_step = sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~sum[XLEN]};
        end else begin
            hi_step = sum[XLEN:1];
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Next-state, counter, result and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        a_raw_d  = a_raw_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    op_d    = funct3;
                    a_raw_d = a;
                    a_mag_d = in_a_mag;
                    b_mag_d = in_b_mag;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    dz_d    = in_div && (b == '0);
                    ovf_d   = in_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
                    hi_d    = '0;
                    lo_d    = in_div ? in_a_mag : in_b_mag;
                    state_d = CALC;
                    cnt_d   = CW'(XLEN);
`ifdef MULDIV_FAST_ZERO_EN
                    if (a == '0 || b == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        if (in_div && b == '0)
                            result_d = funct3[1] ? a : '1;
                        else
                            result_d = '0;
                    end
`endif
                end
            end
            CALC: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = fixup(op_q, hi_step, lo_step, a_neg_q, b_neg_q,
                                     dz_q, ovf_q, a_raw_q);
                end
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand context and iteration datapath
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        a_raw_q <= a_raw_d;
        a_mag_q <= a_mag_d;
        b_mag_q <= b_mag_d;
        a_neg_q <= a_neg_d;
        b_neg_q <= b_neg_d;
        dz_q    <= dz_d;
        ovf_q   <= ovf_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
    end

    assign start_ready  = (state_q == IDLE) && !rst;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed testbench for muldiv_seq_unit (XLEN = 64).
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  funct3;
    logic [63:0] a, b;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 65;
`endif

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_seq_unit #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .funct3       (funct3),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for start_ready, present one request, and scramble inputs after accept
    task automatic issue(input logic [2:0] f, input logic [63:0] av, input logic [63:0] bv);
        int w;
        w = 0;
        @(negedge clk);
        while (!start_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        funct3      = f;
        a           = av;
        b           = bv;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        funct3      = ~f;
        a           = ~av;
        b           = ~bv;
    endtask

    // Count cycles after the accept edge until result_valid (bounded)
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, "_srdy"}, 64'(start_ready), 64'd0);
        end while (!result_valid && lat < 200);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] expv, input int explat);
        int lat;
        issue(f, av, bv);
        wait_valid(tag, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(explat));
        chk(tag, result, expv);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst          = 1'b1;
        flush        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        funct3       = 3'b000;
        a            = '0;
        b            = '0;

        // Reset state
        @(negedge clk);
        chk("rst_srdy", 64'(start_ready), 64'd0);
        chk("rst_rvld", 64'(result_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_srdy", 64'(start_ready), 64'd1);

        // Multiply
        run_op("mul_7x-3", MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_op("mulhu_max", MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("mulh_m1m1", MULH, '1, '1, 64'd0, 65);
        run_op("mulhsu_m1x2", MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("mul_0x5", MUL, 64'd0, 64'd5, 64'd0, ZLAT);

        // Divide / remainder
        run_op("div_m7_2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 65);

        // Divide by zero and signed overflow
        run_op("divu_100_0", DIVU, 64'd100, 64'd0, '1, ZLAT);
        run_op("rem_100_0", REM, 64'd100, 64'd0, 64'd100, ZLAT);
        run_op("div_ovf", DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65);
        run_op("rem_ovf", REM, 64'h8000_0000_0000_0000, '1, 64'd0, 65);

        // Backpressure: result held, no accept while DONE
        issue(DIVU, 64'd100, 64'd7);
        wait_valid("bp", lat);
        chk("bp_lat", 64'(lat), 64'd65);
        start_valid = 1'b1;
        funct3      = MUL;
        a           = 64'd2;
        b           = 64'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res", result, 64'd14);
            chk("bp_rvld", 64'(result_valid), 64'd1);
            chk("bp_srdy", 64'(start_ready), 64'd0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk("bp_srdy_after", 64'(start_ready), 64'd1);
        chk("bp_busy_after", 64'(busy), 64'd0);
        chk("bp_rvld_after", 64'(result_valid), 64'd0);
        start_valid = 1'b0;

        // Flush coincident with a request in IDLE: not accepted
        @(negedge clk);
        start_valid = 1'b1;
        flush       = 1'b1;
        funct3      = MUL;
        a           = 64'd3;
        b           = 64'd5;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush       = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 64'(busy), 64'd0);

        // Flush in CALC cycle 20
        issue(MUL, 64'd3, 64'd5);
        repeat (20) @(negedge clk);
        chk("fl_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_srdy", 64'(start_ready), 64'd1);
        chk("fl_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("fl_no_rvld", 64'(seen), 64'd0);

        // Reset pulse in CALC cycle 30
        issue(MUL, 64'd3, 64'd5);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_srdy", 64'(start_ready), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_rvld", 64'(result_valid), 64'd0);
        chk("mrst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_srdy_rel", 64'(start_ready), 64'd1);

        run_op("mul_3x5", MUL, 64'd3, 64'd5, 64'd15, 65);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

Iterative multi-cycle sequencer for the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the execute stage, beside the single-cycle ALU. It latches operands through a valid/ready handshake and runs a one-bit-per-cycle shift-add multiply or restoring divide on an internal add/subtract datapath. It applies RISC-V sign and special-case rules, then holds the result until the consumer accepts it. The pipeline stalls on `start_ready` low and on `result_valid` low.

## Interface
- `XLEN`, 64, operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of any in-flight or held operation.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  unit can accept; high only in IDLE.
- `funct3`  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, `b`  in  XLEN  rs1/rs2 operands, sampled on accept.
- `result_valid`  out  1  result held.
- `result_ready`  in  1  consumer accepts.
- `result`  out  XLEN  registered result.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: accept when `start_valid && start_ready`; latch `funct3`, operand magnitudes and sign flags; go to CALC, or go to DONE via fast path (see Configuration).
  - CALC: run `XLEN` iterations with a down-counter, then go to DONE.
  - DONE: hold `result`/`result_valid`; on `result_ready` go to IDLE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes are taken at accept; the final sign fix is a two's-complement negate.
- Multiply: 2·XLEN-bit accumulator, shift-add over |b|. The product is negative when the signed-operand signs differ. MUL returns the low XLEN bits; MULH* return the high XLEN bits of the sign-corrected 2·XLEN product.
- Divide: restoring, one quotient bit per cycle via trial subtract of |b| from the partial remainder.
  - Quotient is negated when signs differ; remainder takes the sign of `a`.
- Special cases are forced in the final fixup, independent of the macro:
  - divide by zero: quotient all-ones, remainder = `a`.
  - signed overflow (`a` = most-negative, `b` = −1): quotient = `a`, remainder = 0.
- Operand/funct3 changes after accept are ignored. All 8 `funct3` codes are legal.
- `flush`: highest priority after `rst`. Any state → IDLE at the next edge; `result_valid` drops and the held result is discarded. `flush` coincident with `start_valid` in IDLE: request not accepted.
- Reset values: state IDLE, `result` 0, `result_valid` 0, counter 0, `busy` 0. `start_ready` is 0 while `rst` is high and 1 after release.

## Timing
- Accept edge = cycle 0.
- Normal latency: CALC occupies cycles 1..XLEN; `result_valid` first high in cycle XLEN+1 (65 for XLEN=64).
- Fast path: `result_valid` high in cycle 1.
- `result`/`result_valid` are registered and stable while `result_ready` is low; no combinational path from inputs to outputs except `start_ready` = (state == IDLE) && !rst.
- No accept in DONE. The earliest next accept is the cycle after the result handshake. Throughput is one op per XLEN+2 cycles with `result_ready` held high.
- `rst` mid-operation: immediate return to reset values; no result produced.

## Configuration
- `MULDIV_FAST_ZERO_EN` defined: an accepted op with `a` == 0 or `b` == 0 skips CALC and produces its result in cycle 1.
  - MUL*: 0.
  - DIV/DIVU: all-ones if `b` == 0, else 0.
  - REM/REMU: `a` if `b` == 0, else 0.
- Undefined: every op takes the full XLEN+1 cycles. Result values are identical either way; only latency differs.

## Test plan
- MUL `a`=7, `b`=−3 → `result` 0xFFFF_FFFF_FFFF_FFEB, `result_valid` in cycle 65; MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE; MULH −1 × −1 → 0.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 100/0 → all-ones; REM 100/0 → 100. Valid in cycle 1 with `MULDIV_FAST_ZERO_EN`, cycle 65 without.
- DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM same operands → 0.
- Backpressure: hold `result_ready` low 10 cycles after valid → `result` stable, `start_ready` 0, second `start_valid` not accepted; raise `result_ready` → `start_ready` 1 next cycle.
- `flush` at cycle 20 of CALC → `result_valid` never asserts, `start_ready` 1 next cycle. `rst` pulse at cycle 30 → all outputs at reset values immediately. A following MUL 3×5 then returns 15.
